// File: rtl/boxhead_pkg.sv
// Shared game constants, player state encoding and blood arithmetic helper
// for the player damage path and the per-enemy gamelogic.
package boxhead_pkg;

  localparam int ENEMY_NUM         = 4;
  localparam int SPRITE_SIZE       = 26;
  localparam int PLAYER_FULL_BLOOD = 100;
  localparam int ENEMY_HIT_DAMAGE  = 10;
  localparam int INVULN_FRAMES     = 30;
  localparam int DEATH_FRAMES      = 60;
  localparam int REGEN_PERIOD      = 60;

  typedef enum logic [1:0] {
    ALIVE = 2'd0,
    HURT  = 2'd1,
    DYING = 2'd2,
    OVER  = 2'd3
  } player_state_t;

  // Blood never wraps below zero.
  function automatic logic [6:0] sat_sub_blood(input logic [6:0] blood, input logic [6:0] dmg);
    return (blood > dmg) ? blood - dmg : 7'd0;
  endfunction

endpackage

// File: rtl/player_contact_detect.sv
// Combinational enemy/player bounding-box overlap test with a lowest-index
// priority encoder over the contacting enemies.
module player_contact_detect #(
  parameter int ENEMY_NUM   = 4,
  parameter int SPRITE_SIZE = 26,
  parameter int IDX_W       = $clog2(ENEMY_NUM)
) (
  input  logic [8:0]             player_x,
  input  logic [8:0]             player_y,
  input  logic [ENEMY_NUM*9-1:0] enemy_x,
  input  logic [ENEMY_NUM*9-1:0] enemy_y,
  input  logic [ENEMY_NUM-1:0]   enemy_alive,
  output logic [ENEMY_NUM-1:0]   contact,
  output logic                   any_contact,
  output logic [IDX_W-1:0]       lowest_idx
);

  localparam logic [9:0] SIZE = 10'(SPRITE_SIZE);

  logic [9:0] px;
  logic [9:0] py;

  // Ten-bit operands keep position + size from wrapping near the screen edge.
  assign px = {1'b0, player_x};
  assign py = {1'b0, player_y};

  for (genvar i = 0; i < ENEMY_NUM; i++) begin : g_enemy
    logic [9:0] ex;
    logic [9:0] ey;
    assign ex = {1'b0, enemy_x[9*i +: 9]};
    assign ey = {1'b0, enemy_y[9*i +: 9]};
    assign contact[i] = enemy_alive[i]
                        && (ex + SIZE >= px) && (ex <= px + SIZE)
                        && (ey + SIZE >= py) && (ey <= py + SIZE);
  end

  assign any_contact = |contact;

  always_comb begin
    lowest_idx = '0;
    for (int i = ENEMY_NUM - 1; i >= 0; i--) begin
      if (contact[i]) lowest_idx = IDX_W'(i);
    end
  end

endmodule

// File: rtl/player_health_ctrl.sv
// Player blood, invulnerability and death sequencing driven by enemy contact.
// Optional blood regeneration in ALIVE is built when PLAYER_REGEN_EN is defined.
module player_health_ctrl #(
  parameter int ENEMY_NUM         = boxhead_pkg::ENEMY_NUM,
  parameter int SPRITE_SIZE       = boxhead_pkg::SPRITE_SIZE,
  parameter int PLAYER_FULL_BLOOD = boxhead_pkg::PLAYER_FULL_BLOOD,
  parameter int ENEMY_HIT_DAMAGE  = boxhead_pkg::ENEMY_HIT_DAMAGE,
  parameter int INVULN_FRAMES     = boxhead_pkg::INVULN_FRAMES,
`ifdef PLAYER_REGEN_EN
  parameter int REGEN_PERIOD      = boxhead_pkg::REGEN_PERIOD,
`endif
  parameter int DEATH_FRAMES      = boxhead_pkg::DEATH_FRAMES
) (
  input  logic                         Clk,
  input  logic                         Reset,
  input  logic                         game_frame_clk_rising_edge,
  input  logic [8:0]                   Player_X,
  input  logic [8:0]                   Player_Y,
  input  logic [ENEMY_NUM*9-1:0]       Enemy_X,
  input  logic [ENEMY_NUM*9-1:0]       Enemy_Y,
  input  logic [ENEMY_NUM-1:0]         Enemy_Alive,
  output logic [6:0]                   Player_Blood,
  output logic                         Player_Alive,
  output logic                         Player_Is_Attacked,
  output logic [$clog2(ENEMY_NUM)-1:0] Hit_Enemy_Idx,
  output logic [7:0]                   Hit_Count,
  output logic                         Game_Over,
  output logic [1:0]                   dbg_state,
  output logic [ENEMY_NUM-1:0]         dbg_contact
);

  import boxhead_pkg::*;

  localparam int         IDX_W = $clog2(ENEMY_NUM);
  localparam logic [6:0] FULL  = 7'(PLAYER_FULL_BLOOD);
  localparam logic [6:0] DMG   = 7'(ENEMY_HIT_DAMAGE);
  localparam logic [7:0] INV   = 8'(INVULN_FRAMES);
  localparam logic [7:0] DEATH = 8'(DEATH_FRAMES);

  player_state_t    state, state_n;
  logic [6:0]       blood, blood_n;
  logic [7:0]       frame_cnt, frame_cnt_n;
  logic [IDX_W-1:0] idx, idx_n;
  logic [7:0]       hits, hits_n;
  logic             any_contact;
  logic [IDX_W-1:0] lowest_idx;
`ifdef PLAYER_REGEN_EN
  localparam logic [7:0] REGEN = 8'(REGEN_PERIOD);
  logic [7:0]       regen_cnt, regen_cnt_n;
`endif

  player_contact_detect #(
    .ENEMY_NUM   (ENEMY_NUM),
    .SPRITE_SIZE (SPRITE_SIZE),
    .IDX_W       (IDX_W)
  ) u_contact (
    .player_x    (Player_X),
    .player_y    (Player_Y),
    .enemy_x     (Enemy_X),
    .enemy_y     (Enemy_Y),
    .enemy_alive (Enemy_Alive),
    .contact     (dbg_contact),
    .any_contact (any_contact),
    .lowest_idx  (lowest_idx)
  );

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state     <= ALIVE;
      blood     <= FULL;
      frame_cnt <= '0;
      idx       <= '0;
      hits      <= '0;
`ifdef PLAYER_REGEN_EN
      regen_cnt <= '0;
`endif
    end else begin
      state     <= state_n;
      blood     <= blood_n;
      frame_cnt <= frame_cnt_n;
      idx       <= idx_n;
      hits      <= hits_n;
`ifdef PLAYER_REGEN_EN
      regen_cnt <= regen_cnt_n;
`endif
    end
  end

  always_comb begin
    state_n     = state;
    blood_n     = blood;
    frame_cnt_n = frame_cnt;
    idx_n       = idx;
    hits_n      = hits;
`ifdef PLAYER_REGEN_EN
    regen_cnt_n = regen_cnt;
`endif
    if (game_frame_clk_rising_edge) begin
      case (state)
        ALIVE: begin
          // Simultaneous contacts still cost a single hit.
          if (any_contact) begin
            idx_n   = lowest_idx;
            hits_n  = (hits == 8'hFF) ? hits : hits + 8'd1;
            blood_n = sat_sub_blood(blood, DMG);
`ifdef PLAYER_REGEN_EN
            regen_cnt_n = '0;
`endif
            if (blood_n == '0) begin
              state_n     = DYING;
              frame_cnt_n = DEATH;
            end else begin
              state_n     = HURT;
              frame_cnt_n = INV;
            end
          end
`ifdef PLAYER_REGEN_EN
          else if (regen_cnt == REGEN - 8'd1) begin
            regen_cnt_n = '0;
            if (blood < FULL) blood_n = blood + 7'd1;
          end else begin
            regen_cnt_n = regen_cnt + 8'd1;
          end
`endif
        end
        HURT: begin
          frame_cnt_n = frame_cnt - 8'd1;
          if (frame_cnt == 8'd1) state_n = ALIVE;
        end
        DYING: begin
          frame_cnt_n = frame_cnt - 8'd1;
          if (frame_cnt == 8'd1) state_n = OVER;
        end
        default: ;
      endcase
    end
  end

  assign Player_Blood       = blood;
  assign Player_Alive       = (state == ALIVE) || (state == HURT);
  assign Player_Is_Attacked = (state == HURT);
  assign Hit_Enemy_Idx      = idx;
  assign Hit_Count          = hits;
  assign Game_Over          = (state == OVER);
  assign dbg_state          = state;

endmodule

// File: tb/tb_player_health_ctrl.sv
// Directed bench for player_health_ctrl: a reference model feeds an expected
// queue every cycle, plus fixed-value checks at the key points of each scenario.
module tb_player_health_ctrl;
  import boxhead_pkg::*;

  localparam int W     = 22;
  localparam int B_DMG = 19;

  logic clk = 1'b0;
  logic rst_a, rst_b, strobe;
  logic [8:0] px, py;
  logic [ENEMY_NUM*9-1:0] ex, ey;
  logic [ENEMY_NUM-1:0] ealive;

  logic [6:0] blood_a, blood_b;
  logic       alive_a, alive_b, att_a, att_b, over_a, over_b;
  logic [1:0] idx_a, idx_b, st_a, st_b;
  logic [7:0] hits_a, hits_b;
  logic [ENEMY_NUM-1:0] con_a, con_b;

  logic [W-1:0] exp_q[$];
  int total  = 0;
  int passed = 0;
  int m_state, m_blood, m_cnt, m_idx, m_hits, m_regen;

  // clock / reset
  always #5 clk = ~clk;

  player_health_ctrl dut_a (
    .Clk(clk), .Reset(rst_a), .game_frame_clk_rising_edge(strobe),
    .Player_X(px), .Player_Y(py), .Enemy_X(ex), .Enemy_Y(ey), .Enemy_Alive(ealive),
    .Player_Blood(blood_a), .Player_Alive(alive_a), .Player_Is_Attacked(att_a),
    .Hit_Enemy_Idx(idx_a), .Hit_Count(hits_a), .Game_Over(over_a),
    .dbg_state(st_a), .dbg_contact(con_a)
  );

  player_health_ctrl #(.ENEMY_HIT_DAMAGE(B_DMG)) dut_b (
    .Clk(clk), .Reset(rst_b), .game_frame_clk_rising_edge(strobe),
    .Player_X(px), .Player_Y(py), .Enemy_X(ex), .Enemy_Y(ey), .Enemy_Alive(ealive),
    .Player_Blood(blood_b), .Player_Alive(alive_b), .Player_Is_Attacked(att_b),
    .Hit_Enemy_Idx(idx_b), .Hit_Count(hits_b), .Game_Over(over_b),
    .dbg_state(st_b), .dbg_contact(con_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // reference model
  function automatic logic [ENEMY_NUM-1:0] m_contact();
    logic [ENEMY_NUM-1:0] c;
    int exi, eyi, pxi, pyi;
    c = '0;
    pxi = int'(px);
    pyi = int'(py);
    for (int i = 0; i < ENEMY_NUM; i++) begin
      exi = int'(ex[i*9 +: 9]);
      eyi = int'(ey[i*9 +: 9]);
      c[i] = ealive[i] && (exi + SPRITE_SIZE >= pxi) && (exi <= pxi + SPRITE_SIZE)
             && (eyi + SPRITE_SIZE >= pyi) && (eyi <= pyi + SPRITE_SIZE);
    end
    return c;
  endfunction

  task automatic model_step();
    logic [ENEMY_NUM-1:0] c;
    int first;
    if (rst_a) begin
      m_state = 0; m_blood = PLAYER_FULL_BLOOD; m_cnt = 0;
      m_idx = 0; m_hits = 0; m_regen = 0;
      return;
    end
    if (!strobe) return;
    c = m_contact();
    first = -1;
    for (int i = ENEMY_NUM - 1; i >= 0; i--) if (c[i]) first = i;
    case (m_state)
      0: begin
        if (first >= 0) begin
          m_idx = first;
          if (m_hits < 255) m_hits++;
          m_blood = (m_blood > ENEMY_HIT_DAMAGE) ? m_blood - ENEMY_HIT_DAMAGE : 0;
          m_regen = 0;
          if (m_blood == 0) begin m_state = 2; m_cnt = DEATH_FRAMES; end
          else begin m_state = 1; m_cnt = INVULN_FRAMES; end
        end else begin
`ifdef PLAYER_REGEN_EN
          m_regen++;
          if (m_regen == REGEN_PERIOD) begin
            m_regen = 0;
            if (m_blood < PLAYER_FULL_BLOOD) m_blood++;
          end
`endif
        end
      end
      1: begin m_cnt--; if (m_cnt == 0) m_state = 0; end
      2: begin m_cnt--; if (m_cnt == 0) m_state = 3; end
      default: ;
    endcase
  endtask

  function automatic logic [W-1:0] model_pack();
    return {m_state[1:0], m_blood[6:0], (m_state < 2), (m_state == 1),
            m_idx[1:0], m_hits[7:0], (m_state == 3)};
  endfunction

  function automatic logic [W-1:0] dut_pack_a();
    return {st_a, blood_a, alive_a, att_a, idx_a, hits_a, over_a};
  endfunction

  // driver tasks; every cycle goes through the scoreboard
  task automatic do_cycle();
    logic [W-1:0] e;
    logic [ENEMY_NUM-1:0] ce;
    model_step();
    exp_q.push_back(model_pack());
    ce = m_contact();
    @(negedge clk);
    e = exp_q.pop_front();
    chk("scoreboard_a", dut_pack_a(), e);
    chk("contact_a", con_a, ce);
  endtask

  task automatic do_strobe();
    strobe = 1'b1;
    do_cycle();
    strobe = 1'b0;
  endtask

  task automatic strobes(input int n);
    for (int k = 0; k < n; k++) do_strobe();
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) do_cycle();
  endtask

  task automatic set_enemy(input int i, input int x, input int y);
    ex[i*9 +: 9] = 9'(x);
    ey[i*9 +: 9] = 9'(y);
  endtask

  task automatic far_all();
    for (int i = 0; i < ENEMY_NUM; i++) set_enemy(i, 400, 400);
  endtask

  initial begin
    rst_a = 1'b1; rst_b = 1'b1; strobe = 1'b0;
    px = 9'd110; py = 9'd110; ex = '0; ey = '0; ealive = '1;
    far_all();
    idle(2);
    chk("reset_blood", blood_a, 100);
    chk("reset_alive", alive_a, 1);
    chk("reset_attacked", att_a, 0);
    chk("reset_idx", idx_a, 0);
    chk("reset_hits", hits_a, 0);
    chk("reset_over", over_a, 0);
    chk("reset_state", st_a, 0);
    rst_a = 1'b0;

    strobes(5);
    chk("quiet_blood", blood_a, 100);
    chk("quiet_alive", alive_a, 1);
    chk("quiet_hits", hits_a, 0);

    set_enemy(2, 100, 100);
    do_strobe();
    chk("hit1_blood", blood_a, 90);
    chk("hit1_idx", idx_a, 2);
    chk("hit1_attacked", att_a, 1);
    chk("hit1_hits", hits_a, 1);
    idle(3);
    chk("hold_blood", blood_a, 90);
    strobes(29);
    chk("hurt29_attacked", att_a, 1);
    chk("hurt29_blood", blood_a, 90);
    do_strobe();
    chk("hurt_end_attacked", att_a, 0);
    chk("hurt_end_blood", blood_a, 90);
    do_strobe();
    chk("rehit_blood", blood_a, 80);
    chk("rehit_hits", hits_a, 2);

    far_all(); strobes(30);
    set_enemy(1, 120, 90); set_enemy(3, 90, 120);
    do_strobe();
    chk("multi_blood", blood_a, 70);
    chk("multi_idx", idx_a, 1);
    chk("multi_hits", hits_a, 3);

    far_all(); strobes(30);
    set_enemy(0, 110, 110); ealive[0] = 1'b0;
    do_strobe();
    chk("dead_enemy_blood", blood_a, 70);
    chk("dead_enemy_state", st_a, 0);
    ealive = '1;

    set_enemy(0, 137, 110); do_strobe();
    chk("edge_out_blood", blood_a, 70);
    set_enemy(0, 136, 110); do_strobe();
    chk("edge_in_blood", blood_a, 60);
    chk("edge_in_idx", idx_a, 0);

    far_all(); strobes(30);
    px = 9'd505; py = 9'd505; set_enemy(3, 490, 490);
    do_strobe();
    chk("nowrap_blood", blood_a, 50);
    chk("nowrap_idx", idx_a, 3);
    strobes(30);
    for (int h = 0; h < 4; h++) begin do_strobe(); strobes(30); end
    chk("low_blood", blood_a, 10);
    do_strobe();
    chk("die_blood", blood_a, 0);
    chk("die_state", st_a, 2);
    chk("die_alive", alive_a, 0);
    chk("die_attacked", att_a, 0);
    strobes(10);
    rst_a = 1'b1; do_strobe(); rst_a = 1'b0;
    chk("rst_dying_blood", blood_a, 100);
    chk("rst_dying_state", st_a, 0);
    chk("rst_dying_over", over_a, 0);
    chk("rst_dying_hits", hits_a, 0);

    px = 9'd110; py = 9'd110; far_all(); set_enemy(2, 100, 100);
    do_strobe(); far_all();
    chk("regen_start_blood", blood_a, 90);
    strobes(150);
`ifdef PLAYER_REGEN_EN
    chk("regen_120_blood", blood_a, 92);
`else
    chk("no_regen_120_blood", blood_a, 90);
`endif
    strobes(58); set_enemy(2, 100, 100); do_strobe(); far_all();
    strobes(89);
`ifdef PLAYER_REGEN_EN
    chk("regen_restart_blood", blood_a, 82);
    do_strobe();
    chk("regen_after_restart", blood_a, 83);
`else
    chk("no_regen_restart_blood", blood_a, 80);
    do_strobe();
    chk("no_regen_after_restart", blood_a, 80);
`endif
    rst_a = 1'b1; do_cycle(); rst_a = 1'b0;
    strobes(60);
    chk("full_cap_blood", blood_a, 100);

    // second instance: damage that does not divide full blood
    rst_a = 1'b1; far_all(); set_enemy(2, 100, 100); rst_b = 1'b0;
    for (int h = 1; h <= 5; h++) begin
      do_strobe();
      chk("b_hit_blood", blood_b, 32'(100 - B_DMG * h));
      strobes(30);
    end
    chk("b_idx", idx_b, 2);
    chk("b_contact", con_b, 4'b0100);
    do_strobe();
    chk("b_sat_blood", blood_b, 0);
    chk("b_sat_state", st_b, 2);
    chk("b_sat_alive", alive_b, 0);
    chk("b_sat_attacked", att_b, 0);
    chk("b_sat_hits", hits_b, 6);
    strobes(59);
    chk("b_dying_over", over_b, 0);
    chk("b_dying_state", st_b, 2);
    chk("b_dying_blood", blood_b, 0);
    do_strobe();
    chk("b_over", over_b, 1);
    chk("b_over_state", st_b, 3);
    for (int k = 0; k < 100; k++) begin
      do_strobe();
      chk("b_over_hold", over_b, 1);
    end
    chk("b_over_alive", alive_b, 0);
    chk("b_over_blood", blood_b, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/player_health_ctrl.md
Name: player_health_ctrl

Overview:
- Enemy-to-player damage path, mirroring the per-enemy damage logic: detects enemy/player body contact, deducts player blood, enforces invulnerability frames, and runs the player death/game-over sequence.
- Sits beside the per-enemy gamelogic instances.
- Consumes the same 9-bit positions and the same game_frame_clk_rising_edge strobe.
- Drives the HUD blood bar and the top-level game state.

Parameters:
- ENEMY_NUM, 4, number of enemy instances observed.
- SPRITE_SIZE, 26, player and enemy bounding-box side in pixels.
- PLAYER_FULL_BLOOD, 100, blood after reset (7-bit).
- ENEMY_HIT_DAMAGE, 10, blood removed per accepted hit.
- INVULN_FRAMES, 30, frames of hit immunity after an accepted hit.
- DEATH_FRAMES, 60, frames spent in the dying animation before game over.
- REGEN_PERIOD, 60, frames per +1 blood (optional feature only).

Ports:
- Clk  in  1  system clock
- Reset  in  1  synchronous, active-high reset
- game_frame_clk_rising_edge  in  1  one-Clk-cycle strobe per frame; all state updates are qualified by it
- Player_X, Player_Y  in  9  player top-left position
- Enemy_X, Enemy_Y  in  ENEMY_NUM*9  packed enemy positions; enemy i occupies bits [9i+8:9i]
- Enemy_Alive  in  ENEMY_NUM  per-enemy alive flags
- Player_Blood  out  7  current blood
- Player_Alive  out  1  high in ALIVE and HURT
- Player_Is_Attacked  out  1  high throughout HURT
- Hit_Enemy_Idx  out  $clog2(ENEMY_NUM)  index of the enemy that scored the last accepted hit
- Hit_Count  out  8  accepted hits, saturating at 255
- Game_Over  out  1  high in OVER

Behaviour:
- Reset values:
  - state = ALIVE, Player_Blood = PLAYER_FULL_BLOOD, Player_Alive = 1.
  - Player_Is_Attacked = 0, Hit_Enemy_Idx = 0, Hit_Count = 0, Game_Over = 0.
  - frame counter = 0.
- Reset has priority over everything, including a strobe in the same cycle and any state.
- Contact for enemy i:
  - Condition: Enemy_Alive[i] && Ex+S >= Px && Ex <= Px+S && Ey+S >= Py && Ey <= Py+S.
  - Comparisons use 10-bit zero-extended operands, so there is no 9-bit wrap.
- Outside strobe cycles, every register holds its value.
- States: ALIVE, HURT, DYING, OVER. All transitions occur only on strobe cycles.
- ALIVE, strobe with any contact (accepted hit):
  - Exactly one hit is taken, however many enemies are in contact (no stacking).
  - Hit_Enemy_Idx = lowest contacting index.
  - Hit_Count += 1, saturating.
  - Blood = max(Blood - ENEMY_HIT_DAMAGE, 0), saturating at 0, never wrapping.
  - If the new blood is 0: go to DYING, counter = DEATH_FRAMES.
  - Otherwise: go to HURT, counter = INVULN_FRAMES.
- ALIVE, strobe without contact: stay in ALIVE.
- HURT:
  - Each strobe decrements the counter; contact is ignored.
  - On the strobe where the counter is 1, go to ALIVE. HURT therefore lasts exactly INVULN_FRAMES strobes.
  - The first contact that can be accepted again is on the following strobe.
- DYING:
  - Player_Alive = 0, Player_Is_Attacked = 0, blood held at 0.
  - Counter decrements each strobe; at 1, go to OVER.
- OVER:
  - Game_Over = 1, Player_Alive = 0.
  - Terminal; only Reset exits.
- Outputs are registered: values follow the strobe cycle by one Clk (one-cycle latency).
- Enemy_Alive falling in the same cycle as contact: that enemy does not count.

Optional Feature:
- Macro: PLAYER_REGEN_EN.
- Defined:
  - In ALIVE only, a regen counter increments per strobe.
  - When it reaches REGEN_PERIOD, blood += 1, saturating at PLAYER_FULL_BLOOD, and the counter clears.
  - Any accepted hit clears the regen counter; a hit on the same strobe wins over regen.
  - The regen counter is held at 0 outside ALIVE and is cleared on Reset.
- Undefined: no regen logic or counter exists; blood only decreases until Reset.

Decomposition:
- Package boxhead_pkg:
  - player_state_t enum {ALIVE, HURT, DYING, OVER}.
  - Constants shared with gamelogic: ENEMY_NUM, SPRITE_SIZE, PLAYER_FULL_BLOOD, ENEMY_HIT_DAMAGE.
- Sub-module player_contact_detect: combinational, parameterized by ENEMY_NUM and SPRITE_SIZE.
  - Outputs: a contact vector, any_contact, and lowest_idx via a priority encoder.
  - Instantiated once.

Test Plan:
- Reset, then 5 strobes with no contact -> Blood=100, Player_Alive=1, Game_Over=0, Hit_Count=0.
- Enemy 2 overlapping player (E=(100,100), P=(110,110)) for 1 strobe -> Blood=90, Hit_Enemy_Idx=2, Player_Is_Attacked=1 for 30 strobes; contact held during those strobes -> Blood stays 90; hit on strobe 31 -> Blood=80.
- Enemies 1 and 3 both in contact on one strobe -> Blood drops by 10 only, Hit_Enemy_Idx=1; enemy 0 overlapping with Enemy_Alive[0]=0 -> no hit.
- Blood=5 (after repeated hits at non-multiple damage) then hit -> Blood=0, no wrap, DYING; Player_Alive=0; after 60 strobes Game_Over=1, held for 100 further strobes.
- Reset asserted during DYING, coincident with a strobe -> next cycle Blood=100, ALIVE, Game_Over=0, Hit_Count=0.
- PLAYER_REGEN_EN: Blood=90, no contact for 120 strobes -> Blood=92; hit at strobe 59 of a period -> counter restarts; Blood=100 stays at 100.
